mp3_frame_sync: RTL and testbench

- Consumes the serial MP3 bitstream produced by the SD/FIFO bit source: one bit per `rea` request, returned with `data_valid` one cycle later.
- Hunts for the MPEG-1 Layer III 12-bit sync word and captures and validates the 32-bit frame header.
- Skips the optional 16-bit CRC and then streams the side-information bits to the downstream side-info decoder.
- Sits between the bit source and the side-info/main-data decoder; resumes sync hunting after each frame's side info.

---
 rtl/mp3_pkg.sv | 24 ++
 rtl/mp3_hdr_check.sv | 24 ++
 rtl/mp3_frame_sync.sv | 119 +++++++++++
 tb/tb_mp3_frame_sync.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp3_pkg.sv
// Shared types and header field positions for the MPEG-1 Layer III frame sync block.
package mp3_pkg;

  typedef enum logic [1:0] {StHunt, StHdr, StCrc, StSide} state_e;

  localparam int unsigned HDR_BITS         = 32;
  localparam int unsigned CRC_BITS         = 16;
  localparam int unsigned SIDE_BITS_MONO   = 136;
  localparam int unsigned SIDE_BITS_STEREO = 256;

  localparam int unsigned ID_POS   = 19;
  localparam int unsigned LAYER_HI = 18;
  localparam int unsigned LAYER_LO = 17;
  localparam int unsigned PROT_POS = 16;
  localparam int unsigned BR_HI    = 15;
  localparam int unsigned BR_LO    = 12;
  localparam int unsigned SF_HI    = 11;
  localparam int unsigned SF_LO    = 10;
  localparam int unsigned MODE_HI  = 7;
  localparam int unsigned MODE_LO  = 6;

  localparam logic [1:0] LAYER_III = 2'b01;

endpackage

// File: rtl/mp3_hdr_check.sv
// Combinational validity check of a captured 32-bit MPEG-1 Layer III frame header.
module mp3_hdr_check
  import mp3_pkg::*;
(
  input  logic [HDR_BITS-1:0] hdr,
  output logic                valid
);

  logic [1:0] layer;
  logic [3:0] bitrate_idx;
  logic [1:0] sf_idx;
  logic       unused_bits;

  always_comb begin
    layer       = hdr[LAYER_HI:LAYER_LO];
    bitrate_idx = hdr[BR_HI:BR_LO];
    sf_idx      = hdr[SF_HI:SF_LO];
    valid = (&hdr[HDR_BITS-1:20]) && hdr[ID_POS] && (layer == LAYER_III) &&
            (bitrate_idx != 4'h0) && (bitrate_idx != 4'hF) && (sf_idx != 2'd3);
  end

  assign unused_bits = ^{hdr[PROT_POS], hdr[9:0]};

endmodule

// File: rtl/mp3_frame_sync.sv
// Serial MP3 frame synchroniser: hunts the sync word, validates the header, skips the CRC
// and streams the side-information bits downstream.
module mp3_frame_sync
  import mp3_pkg::*;
#(
  parameter int unsigned SYNC_BITS = 12,
  parameter int unsigned MAX_FAIL  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        rea,
  input  logic        data_in,
  input  logic        data_valid,
  output logic        hdr_valid,
  output logic [31:0] hdr,
  output logic        protection,
  output logic [15:0] crc,
  output logic        side_bit,
  output logic        side_valid,
  output logic        side_last,
  output logic        mono,
  output logic [7:0]  sync_errors
);

  state_e                state;
  logic [SYNC_BITS-2:0]  sync_sr;
  logic [HDR_BITS-2:0]   hdr_shift;
  logic [8:0]            bit_cnt;
  logic [SYNC_BITS-1:0]  sync_next;
  logic [HDR_BITS-1:0]   hdr_next;
  logic [8:0]            side_len_m1;
  logic                  hdr_ok;

  assign rea         = enable && !rst;
  assign sync_next   = {sync_sr, data_in};
  assign hdr_next    = {hdr_shift, data_in};
  assign side_len_m1 = mono ? 9'(SIDE_BITS_MONO - 1) : 9'(SIDE_BITS_STEREO - 1);

  mp3_hdr_check u_hdr_check (
    .hdr   (hdr_next),
    .valid (hdr_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StHunt;
      sync_sr     <= '0;
      hdr_shift   <= '0;
      bit_cnt     <= '0;
      hdr_valid   <= 1'b0;
      hdr         <= '0;
      protection  <= 1'b0;
      crc         <= '0;
      side_bit    <= 1'b0;
      side_valid  <= 1'b0;
      side_last   <= 1'b0;
      mono        <= 1'b0;
      sync_errors <= '0;
    end else begin
      hdr_valid  <= 1'b0;
      side_valid <= 1'b0;
      side_last  <= 1'b0;
      if (data_valid) begin
        unique case (state)
          StHunt: begin
            sync_sr <= sync_next[SYNC_BITS-2:0];
            if (&sync_next) begin
              // Preloading ones leaves the sync word in the top bits once the rest shifts in.
              state     <= StHdr;
              hdr_shift <= '1;
              bit_cnt   <= 9'(SYNC_BITS);
            end
          end
          StHdr: begin
            hdr_shift <= hdr_next[HDR_BITS-2:0];
            bit_cnt   <= bit_cnt + 9'd1;
            if (bit_cnt == 9'(HDR_BITS - 1)) begin
              bit_cnt <= '0;
              if (hdr_ok) begin
                hdr        <= hdr_next;
                hdr_valid  <= 1'b1;
                mono       <= (hdr_next[MODE_HI:MODE_LO] == 2'b11);
                protection <= !hdr_next[PROT_POS];
                crc        <= '0;
                state      <= hdr_next[PROT_POS] ? StSide : StCrc;
              end else begin
                if (sync_errors != 8'(MAX_FAIL)) sync_errors <= sync_errors + 8'd1;
                sync_sr <= '0;
                state   <= StHunt;
              end
            end
          end
          StCrc: begin
            crc     <= {crc[14:0], data_in};
            bit_cnt <= bit_cnt + 9'd1;
            if (bit_cnt == 9'(CRC_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= StSide;
            end
          end
          StSide: begin
            side_bit   <= data_in;
            side_valid <= 1'b1;
            bit_cnt    <= bit_cnt + 9'd1;
            if (bit_cnt == side_len_m1) begin
              side_last <= 1'b1;
              bit_cnt   <= '0;
              sync_sr   <= '0;
              state     <= StHunt;
            end
          end
          default: state <= StHunt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mp3_frame_sync.sv
// Bench for mp3_frame_sync: table-driven frames, hand-written corner sequences and a
// randomized stream checked against a bit-walking reference parser.
module tb_mp3_frame_sync;

  logic        clk = 1'b0;
  logic        rst, enable, rea, data_in, data_valid;
  logic        hdr_valid, protection, side_bit, side_valid, side_last, mono;
  logic [31:0] hdr;
  logic [15:0] crc;
  logic [7:0]  sync_errors;

  int checks   = 0;
  int failures = 0;

  bit          src_q[$];
  bit          consumed[$];
  bit          side_seen[$];
  bit          exp_side[$];
  logic [31:0] hdr_seen[$];
  int          hv_cnt, sv_cnt, last_cnt, last_at;
  int          exp_err;

  logic [31:0] m_hdrs[$];
  bit          m_sides[$];
  int          m_errs, m_lasts;

  typedef struct {
    logic [31:0] h;
    logic [15:0] c;
    bit          exp_valid;
    bit          exp_prot;
    bit          exp_mono;
    int          side_len;
    bit          side_ones;
  } vec_t;

  vec_t vecs[10];

  mp3_frame_sync #(.SYNC_BITS(12), .MAX_FAIL(255)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .rea         (rea),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .hdr_valid   (hdr_valid),
    .hdr         (hdr),
    .protection  (protection),
    .crc         (crc),
    .side_bit    (side_bit),
    .side_valid  (side_valid),
    .side_last   (side_last),
    .mono        (mono),
    .sync_errors (sync_errors)
  );

  always #5 clk = ~clk;

  // Bit source: answers each request one cycle later.
  initial begin
    logic req;
    data_valid = 1'b0;
    data_in    = 1'b0;
    forever begin
      @(posedge clk);
      req = rea;
      #1;
      if (req && src_q.size() != 0) begin
        data_valid = 1'b1;
        data_in    = src_q.pop_front();
      end else begin
        data_valid = 1'b0;
        data_in    = 1'($urandom);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (data_valid && !rst) consumed.push_back(data_in);
      if (hdr_valid) begin
        hv_cnt++;
        hdr_seen.push_back(hdr);
      end
      if (side_valid) begin
        sv_cnt++;
        side_seen.push_back(side_bit);
      end
      if (side_last) begin
        last_cnt++;
        last_at = sv_cnt;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w, input int n);
    for (int k = n - 1; k >= 0; k--) src_q.push_back(w[k]);
  endtask

  task automatic push_side(input int n, input bit ones);
    bit b;
    exp_side.delete();
    for (int k = 0; k < n; k++) begin
      b = ones ? 1'b1 : 1'($urandom);
      src_q.push_back(b);
      exp_side.push_back(b);
    end
  endtask

  task automatic clear_obs();
    hv_cnt = 0; sv_cnt = 0; last_cnt = 0; last_at = 0;
    hdr_seen.delete();
    side_seen.delete();
  endtask

  task automatic drain();
    int cyc = 0;
    while (src_q.size() != 0 && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("drain", src_q.size(), 0);
  endtask

  function automatic int count_mism(input bit a[$], input bit b[$]);
    int m = 0;
    for (int k = 0; k < a.size() && k < b.size(); k++) if (a[k] != b[k]) m++;
    return m;
  endfunction

  task automatic check_side(input string name, input int len);
    check({name, "_side_count"}, sv_cnt, len);
    check({name, "_last_count"}, last_cnt, 1);
    check({name, "_last_pos"}, last_at, len);
    check({name, "_side_bits"}, count_mism(side_seen, exp_side), 0);
  endtask

  // Reference parser: walks the consumed bit stream using the framing rules directly.
  task automatic run_model();
    int          i, n, run, len;
    logic [31:0] h;
    bit          ok;
    m_hdrs.delete(); m_sides.delete(); m_errs = 0; m_lasts = 0;
    n = consumed.size(); i = 0; run = 0;
    while (i < n) begin
      if (run < 12) begin
        run = consumed[i] ? run + 1 : 0;
        i++;
      end else begin
        if (i + 20 > n) break;
        h = 32'hFFF0_0000;
        for (int k = 0; k < 20; k++) h[19-k] = consumed[i+k];
        i += 20;
        run = 0;
        ok = h[19] && (h[18:17] == 2'b01) && (h[15:12] != 4'h0) && (h[15:12] != 4'hF) &&
             (h[11:10] != 2'd3);
        if (!ok) begin
          if (m_errs < 255) m_errs++;
        end else begin
          m_hdrs.push_back(h);
          if (!h[16]) i += 16;
          len = (h[7:6] == 2'b11) ? 136 : 256;
          for (int k = 0; k < len && i < n; k++) begin
            m_sides.push_back(consumed[i]);
            if (k == len - 1) m_lasts++;
            i++;
          end
        end
      end
    end
  endtask

  initial begin
    int          cyc, base;
    logic [31:0] h;

    vecs[0] = '{32'hFFFB9064, 16'h0000, 1, 0, 0, 256, 0};
    vecs[1] = '{32'hFFFA90C4, 16'hBEEF, 1, 1, 1, 136, 0};
    vecs[2] = '{32'hFFFBF064, 16'h0000, 0, 0, 0, 0,   0};
    vecs[3] = '{32'hFFFB9064, 16'h0000, 1, 0, 0, 256, 1};
    vecs[4] = '{32'hFFF39064, 16'h0000, 0, 0, 0, 0,   0};
    vecs[5] = '{32'hFFFD9064, 16'h0000, 0, 0, 0, 0,   0};
    vecs[6] = '{32'hFFFB0064, 16'h0000, 0, 0, 0, 0,   0};
    vecs[7] = '{32'hFFFB9C64, 16'h0000, 0, 0, 0, 0,   0};
    vecs[8] = '{32'hFFFB90C4, 16'h0000, 1, 0, 1, 136, 0};
    vecs[9] = '{32'hFFFA9044, 16'h1234, 1, 1, 0, 256, 0};

    rst = 1'b1; enable = 1'b1;
    clear_obs();
    repeat (3) @(posedge clk);
    #1;
    check("reset_hdr", hdr, 0);
    check("reset_crc", crc, 0);
    check("reset_prot", protection, 0);
    check("reset_mono", mono, 0);
    check("reset_hdr_valid", hdr_valid, 0);
    check("reset_side_valid", side_valid, 0);
    check("reset_side_last", side_last, 0);
    check("reset_errors", sync_errors, 0);
    check("reset_rea", rea, 0);
    rst = 1'b0;
    #1;
    check("rea_enabled", rea, 1);
    exp_err = 0;

    for (int v = 0; v < 10; v++) begin
      clear_obs();
      push_word(vecs[v].h, 32);
      if (vecs[v].exp_valid && vecs[v].exp_prot) push_word(32'(vecs[v].c), 16);
      if (vecs[v].exp_valid) push_side(vecs[v].side_len, vecs[v].side_ones);
      else exp_err++;
      drain();
      check($sformatf("vec%0d_hdr_valid", v), hv_cnt, 32'(vecs[v].exp_valid));
      check($sformatf("vec%0d_errors", v), sync_errors, exp_err);
      if (vecs[v].exp_valid) begin
        check($sformatf("vec%0d_hdr", v), hdr, vecs[v].h);
        check($sformatf("vec%0d_prot", v), protection, 32'(vecs[v].exp_prot));
        check($sformatf("vec%0d_mono", v), mono, 32'(vecs[v].exp_mono));
        check($sformatf("vec%0d_crc", v), crc, 32'(vecs[v].c));
        check_side($sformatf("vec%0d", v), vecs[v].side_len);
      end
    end

    // Garbage without any long run of ones, then a valid frame.
    clear_obs();
    for (int k = 0; k < 20; k++) src_q.push_back((k % 4 == 3) ? 1'b0 : 1'($urandom));
    push_word(32'hFFFB9064, 32);
    push_side(256, 0);
    drain();
    check("garbage_hdr_valid", hv_cnt, 1);
    check("garbage_hdr", hdr, 32'hFFFB9064);
    check_side("garbage", 256);

    // Thirteen ones: sync on the twelfth, header misaligned and rejected.
    clear_obs();
    src_q.push_back(1'b1);
    push_word(32'hFFFB9064, 32);
    exp_err++;
    push_word(32'hFFFB90C4, 32);
    push_side(136, 0);
    drain();
    check("ones13_hdr_valid", hv_cnt, 1);
    check("ones13_hdr", hdr, 32'hFFFB90C4);
    check("ones13_errors", sync_errors, exp_err);
    check("ones13_mono", mono, 1);
    check_side("ones13", 136);

    // Enable gap in the middle of side info.
    clear_obs();
    push_word(32'hFFFB9064, 32);
    push_side(256, 0);
    cyc = 0;
    while (sv_cnt < 100 && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    check("gap_reached", 32'(sv_cnt >= 100), 1);
    enable = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("gap_rea", rea, 0);
    end
    @(posedge clk);
    #1;
    enable = 1'b1;
    drain();
    check("gap_hdr_valid", hv_cnt, 1);
    check_side("gap", 256);

    // Reset while capturing the header.
    clear_obs();
    push_word(32'hFFFB9064, 32);
    push_side(256, 0);
    base = consumed.size();
    cyc = 0;
    while (consumed.size() < base + 20 && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    check("rst_reached", 32'(consumed.size() >= base + 20), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    src_q.delete();
    check("rst_hdr", hdr, 0);
    check("rst_crc", crc, 0);
    check("rst_mono", mono, 0);
    check("rst_prot", protection, 0);
    check("rst_errors", sync_errors, 0);
    check("rst_side_valid", side_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_err = 0;
    clear_obs();
    push_word(32'hFFFA90C4, 32);
    push_word(32'h0000BEEF, 16);
    push_side(136, 0);
    drain();
    check("post_rst_hdr_valid", hv_cnt, 1);
    check("post_rst_hdr", hdr, 32'hFFFA90C4);
    check("post_rst_crc", crc, 32'hBEEF);
    check("post_rst_prot", protection, 1);
    check("post_rst_errors", sync_errors, 0);
    check_side("post_rst", 136);

    // Randomized stream against the reference parser.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    consumed.delete();
    clear_obs();
    for (int f = 0; f < 8; f++) begin
      repeat ($urandom_range(0, 24)) src_q.push_back(1'($urandom));
      h = {12'hFFF, 20'($urandom)};
      if ($urandom_range(0, 4) != 0) begin
        h[19]    = 1'b1;
        h[18:17] = 2'b01;
        h[15:12] = 4'($urandom_range(1, 14));
        h[11:10] = 2'($urandom_range(0, 2));
      end
      push_word(h, 32);
      if (!h[16]) push_word($urandom, 16);
      push_side((h[7:6] == 2'b11) ? 136 : 256, 0);
    end
    drain();
    run_model();
    check("rnd_hdr_count", hv_cnt, m_hdrs.size());
    for (int k = 0; k < hdr_seen.size() && k < m_hdrs.size(); k++)
      check($sformatf("rnd_hdr%0d", k), hdr_seen[k], m_hdrs[k]);
    check("rnd_side_count", sv_cnt, m_sides.size());
    check("rnd_side_bits", count_mism(side_seen, m_sides), 0);
    check("rnd_last_count", last_cnt, m_lasts);
    check("rnd_errors", sync_errors, m_errs);
    if (m_hdrs.size() != 0) begin
      check("rnd_mono", mono, 32'(m_hdrs[m_hdrs.size()-1][7:6] == 2'b11));
      check("rnd_prot", protection, 32'(!m_hdrs[m_hdrs.size()-1][16]));
    end

    // Saturation of the sync-error counter.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_obs();
    for (int k = 0; k < 260; k++) push_word(32'hFFFBF064, 32);
    drain();
    check("sat_errors", sync_errors, 255);
    check("sat_hdr_valid", hv_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
